// File: rtl/adder_measure_sequencer.sv
// Sequences one adder-loop delay measurement: apply operands, let them settle, enable the loop
// for a fixed window and count synchronised rising edges of the loop output.
module adder_measure_sequencer #(
   parameter int SETTLE_CYCLES = 4,
   parameter int SYNC_STAGES   = 2
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        active,
   input  logic        start,
   input  logic [31:0] a_value,
   input  logic [31:0] b_value,
   input  logic [4:0]  bit_sel,
   input  logic        ext_mode,
   input  logic [15:0] window,
   input  logic        chain_out,
   output logic [31:0] a_input,
   output logic [31:0] b_input,
   output logic [31:0] a_input_ring_bit_b,
   output logic [31:0] a_input_ext_bit_b,
   output logic        run_en,
   output logic        busy,
   output logic        done,
   output logic [31:0] count
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      RUN   = 3'd2,
      DRAIN = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
   localparam logic [15:0] SYNC_LAST   = 16'(SYNC_STAGES - 1);

   state_t                 r_state;
   logic [15:0]            r_cnt;
   logic [15:0]            r_window;
   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;
   logic                   w_sync;
   logic                   w_rise;
   logic [31:0]            w_mask;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   assign w_sync = r_sync[SYNC_STAGES-1];
   assign w_rise = w_sync & ~r_prev;
   assign w_mask = 32'd1 << bit_sel;

   // History follows the synchroniser every cycle, so a level already high when RUN starts is never an edge.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_sync <= '0;
         r_prev <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], chain_out};
         r_prev <= w_sync;
      end
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_state            <= IDLE;
         r_cnt              <= 16'd0;
         r_window           <= 16'd0;
         a_input            <= 32'd0;
         b_input            <= 32'd0;
         a_input_ring_bit_b <= 32'd0;
         a_input_ext_bit_b  <= 32'd0;
         run_en             <= 1'b0;
         busy               <= 1'b0;
         done               <= 1'b0;
         count              <= 32'd0;
      end else if (!active) begin
         r_state            <= IDLE;
         r_cnt              <= 16'd0;
         a_input            <= 32'd0;
         b_input            <= 32'd0;
         a_input_ring_bit_b <= 32'd0;
         a_input_ext_bit_b  <= 32'd0;
         run_en             <= 1'b0;
         busy               <= 1'b0;
         done               <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  r_state            <= SETUP;
                  r_cnt              <= 16'd0;
                  r_window           <= window;
                  a_input            <= a_value;
                  b_input            <= b_value;
                  a_input_ring_bit_b <= ext_mode ? 32'd0 : w_mask;
                  a_input_ext_bit_b  <= ext_mode ? w_mask : 32'd0;
                  busy               <= 1'b1;
                  count              <= 32'd0;
               end
            end
            SETUP: begin
               if (r_cnt == SETTLE_LAST) begin
                  r_cnt <= 16'd0;
                  if (r_window == 16'd0) begin
                     r_state <= DRAIN;
                  end else begin
                     r_state <= RUN;
                     run_en  <= 1'b1;
                  end
               end else begin
                  r_cnt <= r_cnt + 16'd1;
               end
            end
            RUN: begin
               if (w_rise) count <= sat_inc(count);
               if (r_cnt == r_window - 16'd1) begin
                  r_cnt   <= 16'd0;
                  r_state <= DRAIN;
                  run_en  <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + 16'd1;
               end
            end
            DRAIN: begin
               // A zero-length window never enabled the loop, so nothing in flight belongs to it.
               if (w_rise && (r_window != 16'd0)) count <= sat_inc(count);
               if (r_cnt == SYNC_LAST) begin
                  r_cnt              <= 16'd0;
                  r_state            <= DONE;
                  done               <= 1'b1;
                  a_input            <= 32'd0;
                  b_input            <= 32'd0;
                  a_input_ring_bit_b <= 32'd0;
                  a_input_ext_bit_b  <= 32'd0;
               end else begin
                  r_cnt <= r_cnt + 16'd1;
               end
            end
            DONE: begin
               r_state <= IDLE;
               done    <= 1'b0;
               busy    <= 1'b0;
            end
            default: begin
               r_state <= IDLE;
               run_en  <= 1'b0;
               busy    <= 1'b0;
               done    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_adder_measure_sequencer.sv
// Directed bench for adder_measure_sequencer with hand-computed latencies, masks and counts.
module tb_adder_measure_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        active;
   logic        start;
   logic [31:0] a_value;
   logic [31:0] b_value;
   logic [4:0]  bit_sel;
   logic        ext_mode;
   logic [15:0] window;
   logic        chain_out;
   logic [31:0] a_input;
   logic [31:0] b_input;
   logic [31:0] ring_mask;
   logic [31:0] ext_mask;
   logic        run_en;
   logic        busy;
   logic        done;
   logic [31:0] count;

   logic        chain_en;
   logic        chain_level;
   int          checks   = 0;
   int          failures = 0;
   int          dn;
   int          rh;
   int          pc;
   logic [31:0] c1;

   always #5 clk = ~clk;

   adder_measure_sequencer #(.SETTLE_CYCLES(4), .SYNC_STAGES(2)) dut (
      .wb_clk_i           (clk),
      .wb_rst_i           (rst),
      .active             (active),
      .start              (start),
      .a_value            (a_value),
      .b_value            (b_value),
      .bit_sel            (bit_sel),
      .ext_mode           (ext_mode),
      .window             (window),
      .chain_out          (chain_out),
      .a_input            (a_input),
      .b_input            (b_input),
      .a_input_ring_bit_b (ring_mask),
      .a_input_ext_bit_b  (ext_mask),
      .run_en             (run_en),
      .busy               (busy),
      .done               (done),
      .count              (count)
   );

   // Loop output: toggles every 4 clocks, off-edge, or holds a static level.
   initial begin
      chain_out = 1'b0;
      forever begin
         repeat (4) @(posedge clk);
         #3;
         chain_out = chain_en ? ~chain_out : chain_level;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue_start(input logic [31:0] a, input logic [31:0] b, input logic [4:0] sel,
                              input logic e, input logic [15:0] w);
      a_value  = a;
      b_value  = b;
      bit_sel  = sel;
      ext_mode = e;
      window   = w;
      start    = 1'b1;
      step();
      start    = 1'b0;
   endtask

   // n counts cycles since the start cycle; n=1 is the first sample after start was accepted.
   task automatic wait_done(input int limit, output int done_n, output int run_hi, output int pulses);
      done_n = -1;
      run_hi = 0;
      pulses = 0;
      for (int n = 1; n <= limit; n++) begin
         if (done) begin
            pulses++;
            if (done_n < 0) done_n = n;
         end
         if (run_en) run_hi++;
         if (n < limit) step();
      end
   endtask

   initial begin
      rst = 1'b1; active = 1'b1; start = 1'b0;
      a_value = 32'd0; b_value = 32'd0; bit_sel = 5'd0; ext_mode = 1'b0; window = 16'd0;
      chain_en = 1'b1; chain_level = 1'b0;
      repeat (3) step();
      check_eq("rst_busy", busy, 1'b0);
      check_eq("rst_done", done, 1'b0);
      check_eq("rst_run_en", run_en, 1'b0);
      check_eq("rst_count", count, 32'd0);
      check_eq("rst_a_input", a_input, 32'd0);
      check_eq("rst_ring", ring_mask, 32'd0);
      rst = 1'b0;

      // Ring measurement, start accepted on the first edge after reset release.
      issue_start(32'h0000_FFFF, 32'd1, 5'd5, 1'b0, 16'd100);
      check_eq("t1_a_input", a_input, 32'h0000_FFFF);
      check_eq("t1_b_input", b_input, 32'd1);
      check_eq("t1_ring", ring_mask, 32'h0000_0020);
      check_eq("t1_ext", ext_mask, 32'd0);
      check_eq("t1_busy", busy, 1'b1);
      wait_done(200, dn, rh, pc);
      check_eq("t1_done_at", dn, 107);
      check_eq("t1_run_cycles", rh, 100);
      check_eq("t1_done_pulses", pc, 1);
      check_eq("t1_count_12_13", (count >= 32'd12 && count <= 32'd13), 1'b1);
      check_eq("t1_idle_busy", busy, 1'b0);
      check_eq("t1_idle_a_input", a_input, 32'd0);

      // Zero window: no loop enable, no counting.
      issue_start(32'h1234_5678, 32'h8765_4321, 5'd0, 1'b0, 16'd0);
      check_eq("t2_ring", ring_mask, 32'h0000_0001);
      check_eq("t2_count_cleared", count, 32'd0);
      wait_done(50, dn, rh, pc);
      check_eq("t2_done_at", dn, 7);
      check_eq("t2_run_cycles", rh, 0);
      check_eq("t2_done_pulses", pc, 1);
      check_eq("t2_count", count, 32'd0);

      // Second start while in RUN must be ignored.
      issue_start(32'h0000_FFFF, 32'd1, 5'd5, 1'b0, 16'd100);
      wait_done(50, dn, rh, pc);
      check_eq("t3_early_done", pc, 0);
      a_value = 32'hDEAD_BEEF; bit_sel = 5'd9; ext_mode = 1'b1; window = 16'd3;
      start = 1'b1;
      step();
      start = 1'b0;
      check_eq("t3_ring_kept", ring_mask, 32'h0000_0020);
      check_eq("t3_ext_kept", ext_mask, 32'd0);
      check_eq("t3_a_kept", a_input, 32'h0000_FFFF);
      wait_done(150, dn, rh, pc);
      check_eq("t3_done_at", dn, 57);
      check_eq("t3_run_cycles", rh, 54);
      check_eq("t3_done_pulses", pc, 1);
      check_eq("t3_count_12_13", (count >= 32'd12 && count <= 32'd13), 1'b1);

      // Drop active mid-RUN: abort, outputs zero, count frozen, start ignored while inactive.
      issue_start(32'hA5A5_0000, 32'h0000_5A5A, 5'd17, 1'b1, 16'd100);
      check_eq("t4_ext", ext_mask, 32'h0002_0000);
      check_eq("t4_ring", ring_mask, 32'd0);
      wait_done(60, dn, rh, pc);
      check_eq("t4_early_done", pc, 0);
      active = 1'b0;
      step();
      check_eq("t4_run_en", run_en, 1'b0);
      check_eq("t4_busy", busy, 1'b0);
      check_eq("t4_a_input", a_input, 32'd0);
      check_eq("t4_b_input", b_input, 32'd0);
      check_eq("t4_ext_zero", ext_mask, 32'd0);
      c1 = count;
      check_eq("t4_partial_nonzero", (c1 != 32'd0), 1'b1);
      start = 1'b1;
      step();
      start = 1'b0;
      wait_done(150, dn, rh, pc);
      check_eq("t4_no_done", pc, 0);
      check_eq("t4_no_run", rh, 0);
      check_eq("t4_count_frozen", count, c1);
      active = 1'b1;

      // Asynchronous reset pulse between edges during SETUP.
      issue_start(32'hFFFF_0000, 32'd1, 5'd3, 1'b0, 16'd50);
      step();
      #3;
      rst = 1'b1;
      #1;
      check_eq("t5_busy", busy, 1'b0);
      check_eq("t5_a_input", a_input, 32'd0);
      check_eq("t5_ring", ring_mask, 32'd0);
      check_eq("t5_count", count, 32'd0);
      #2;
      rst = 1'b0;
      wait_done(150, dn, rh, pc);
      check_eq("t5_no_done", pc, 0);
      issue_start(32'hFFFF_0000, 32'd1, 5'd7, 1'b0, 16'd10);
      check_eq("t5_ring_after", ring_mask, 32'h0000_0080);
      wait_done(60, dn, rh, pc);
      check_eq("t5_done_at", dn, 17);
      check_eq("t5_run_cycles", rh, 10);
      check_eq("t5_done_pulses", pc, 1);

      // External loop, top bit, loop output held high throughout.
      chain_en = 1'b0;
      chain_level = 1'b1;
      repeat (12) step();
      issue_start(32'h0F0F_0F0F, 32'hF0F0_F0F0, 5'd31, 1'b1, 16'd20);
      check_eq("t6_ext", ext_mask, 32'h8000_0000);
      check_eq("t6_ring", ring_mask, 32'd0);
      wait_done(60, dn, rh, pc);
      check_eq("t6_done_at", dn, 27);
      check_eq("t6_run_cycles", rh, 20);
      check_eq("t6_done_pulses", pc, 1);
      check_eq("t6_count", count, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
